spi_slave_frame: RTL and testbench

- Parametrised successor to the single-word SPI slave used on the spindle/muscle boards.
- Receives a multi-channel frame (NCH words of WIDTH bits) per SSEL assertion and transmits NCH words back on MISO in the same frame.
- Commits received words atomically to a double-buffered output, with frame-length checking.
- Sits between the inter-board SPI header pins and the sim_clk-domain model registers (e.g. muscle length, gamma, rates).

---
 rtl/spi_slave_frame.sv | 198 +++++++++++++++++++
 tb/tb_spi_slave_frame.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_frame.sv
// Multi-channel SPI mode-0 slave: NCH words of WIDTH bits per SSEL frame,
// double-buffered receive commit with frame-length checking.
//
// Ports:
//   clk        system clock; SCK must be at most clk/4
//   reset      asynchronous, active-high
//   SCK        SPI clock from master (mode 0)
//   SSEL       slave select, active-low
//   MOSI       master-out data
//   MISO       slave-out data, 0 whenever no frame is active
//   tx_data    words to send, channel k = [k*WIDTH +: WIDTH]
//   rx_data    last good frame, same channel packing
//   rx_valid   one-clk pulse on a good-frame commit
//   frame_err  one-clk pulse on a bad-length frame
//   busy       high while a frame is active
//   frame_cnt  good-frame count, wraps at 0xFFFF
module spi_slave_frame #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SYNC  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 SCK,
    input  logic                 SSEL,
    input  logic                 MOSI,
    output logic                 MISO,
    input  logic [NCH*WIDTH-1:0] tx_data,
    output logic [NCH*WIDTH-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy,
    output logic [15:0]          frame_cnt
);

    localparam int FLEN = NCH * WIDTH;
    localparam int CW   = $clog2(FLEN + 2);

    localparam logic [CW-1:0] CNT_FULL = CW'(FLEN);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FLEN + 1);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        ACTIVE
    } state_t;

    // Synchronisers. Index SYNC-1 is the synced value, index SYNC the
    // history flop used for edge detection. MOSI is only sampled level-wise
    // at SCK rising edges, so it needs no history stage.
    logic [SYNC:0]   sck_q;
    logic [SYNC:0]   ssel_q;
    logic [SYNC-1:0] mosi_q;

    logic sck_rise;
    logic sck_fall;
    logic ssel_s;
    logic ssel_rise;
    logic ssel_fall;
    logic mosi_s;

    state_t            state_q,     state_d;
    logic [CW-1:0]     cnt_q,       cnt_d;
    logic [FLEN-1:0]   rx_sh_q,     rx_sh_d;
    logic [FLEN-1:0]   tx_sh_q,     tx_sh_d;
    logic [FLEN-1:0]   rx_data_q,   rx_data_d;
    logic              rx_valid_q,  rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    // Word-order remapping between the wire and the channel packing.
    logic [FLEN-1:0]   tx_load;
    logic [FLEN-1:0]   rx_words;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_q  <= '0;
            ssel_q <= '0;
            mosi_q <= '0;
        end else begin
            sck_q  <= {sck_q[SYNC-1:0], SCK};
            ssel_q <= {ssel_q[SYNC-1:0], SSEL};
            mosi_q <= {mosi_q[SYNC-2:0], MOSI};
        end
    end

    assign sck_rise  =  sck_q[SYNC-1] & ~sck_q[SYNC];
    assign sck_fall  = ~sck_q[SYNC-1] &  sck_q[SYNC];
    assign ssel_s    =  ssel_q[SYNC-1];
    assign ssel_rise =  ssel_q[SYNC-1] & ~ssel_q[SYNC];
    assign ssel_fall = ~ssel_q[SYNC-1] &  ssel_q[SYNC];
    assign mosi_s    =  mosi_q[SYNC-1];

    // Channel 0 goes first on the wire, so it sits at the top of both
    // shift registers; the last channel received ends up at the bottom.
    always_comb begin
        tx_load  = '0;
        rx_words = '0;
        for (int k = 0; k < NCH; k++) begin
            tx_load[(NCH-1-k)*WIDTH +: WIDTH] =
                tx_data[k*WIDTH +: WIDTH];
            rx_words[k*WIDTH +: WIDTH] =
                rx_sh_q[(NCH-1-k)*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= WAIT_IDLE;
            cnt_q       <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_sh_d     = tx_sh_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            // After reset, wait for a clean deselect so a frame cut by
            // reset is never half-received.
            WAIT_IDLE: begin
                if (ssel_s) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                if (ssel_fall) begin
                    tx_sh_d = tx_load;
                    cnt_d   = '0;
                    rx_sh_d = '0;
                    state_d = ACTIVE;
                end
            end

            ACTIVE: begin
                // Deselect takes priority over a coincident SCK edge.
                if (ssel_rise) begin
                    state_d = IDLE;
                    if (cnt_q == CNT_FULL) begin
                        rx_data_d   = rx_words;
                        rx_valid_d  = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    if (sck_rise) begin
                        rx_sh_d = {rx_sh_q[FLEN-2:0], mosi_s};
                        // Saturate one past full so over-length
                        // frames stay distinguishable from good ones.
                        if (cnt_q != CNT_SAT) begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    if (sck_fall) begin
                        tx_sh_d = {tx_sh_q[FLEN-2:0], 1'b0};
                    end
                end
            end

            default: begin
                state_d = WAIT_IDLE;
            end
        endcase
    end

    // The tx register shifts in zeros, so MISO drops to 0 after the last
    // bit without extra logic.
    assign MISO      = (state_q == ACTIVE) & tx_sh_q[FLEN-1];
    assign busy      = (state_q == ACTIVE);
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_spi_slave_frame.sv
// Testbench for spi_slave_frame: behavioural frame model, per-cycle compare
// process and a few hand-computed expectations.
module tb_spi_slave_frame;

    localparam int W  = 32;
    localparam int N  = 2;
    localparam int S  = 2;
    localparam int FL = N * W;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          sck   = 1'b0;
    logic          ssel  = 1'b1;
    logic          mosi  = 1'b0;
    logic [FL-1:0] tx_data = '0;
    logic          miso;
    logic [FL-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          busy;
    logic [15:0]   frame_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Frame events announced by the stimulus, as the cycle at which
    // the DUT must show their effect.
    int            ev_fall = -1;
    int            ev_rise = -1;
    int            ev_pre  = -1;
    bit            ev_good = 1'b0;
    logic [FL-1:0] ev_rx   = '0;

    // Model state owned by the compare process.
    logic [FL-1:0] exp_rx   = '0;
    logic [15:0]   exp_cnt  = '0;
    bit            exp_busy = 1'b0;

    spi_slave_frame #(
        .WIDTH (W),
        .NCH   (N),
        .SYNC  (S)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .SCK       (sck),
        .SSEL      (ssel),
        .MOSI      (mosi),
        .MISO      (miso),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [FL-1:0] act,
                       input logic [FL-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit ex_v;
        bit ex_e;
        ex_v = 1'b0;
        ex_e = 1'b0;
        if (reset) begin
            exp_rx   = '0;
            exp_cnt  = '0;
            exp_busy = 1'b0;
        end else begin
            if (cyc == ev_pre)  exp_cnt  = 16'hFFFF;
            if (cyc == ev_fall) exp_busy = 1'b1;
            if (cyc == ev_rise) begin
                exp_busy = 1'b0;
                if (ev_good) begin
                    ex_v    = 1'b1;
                    exp_rx  = ev_rx;
                    exp_cnt = exp_cnt + 16'd1;
                end else begin
                    ex_e = 1'b1;
                end
            end
        end
        chk("rx_valid",  FL'(rx_valid),  FL'(ex_v));
        chk("frame_err", FL'(frame_err), FL'(ex_e));
        chk("busy",      FL'(busy),      FL'(exp_busy));
        chk("rx_data",   rx_data,        exp_rx);
        chk("frame_cnt", FL'(frame_cnt), FL'(exp_cnt));
        if (!exp_busy) chk("miso_idle", FL'(miso), '0);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SSEL-low period at clk/8 SCK. Wire order: word 0 first, MSB
    // first. rst_at pulses reset before that bit; coinc raises SSEL together
    // with the last SCK rise; chg rewrites tx_data mid-frame.
    task automatic frame(input logic [FL-1:0] mo, input int nbits,
                         input int rst_at, input bit coinc, input bit chg,
                         input int gap, output logic [FL-1:0] mi,
                         output logic [FL-1:0] snap);
        bit            track;
        bit            b;
        int            p;
        logic [FL-1:0] exp_mi;
        track  = 1'b1;
        mi     = '0;
        exp_mi = '0;
        snap   = tx_data;
        ssel    = 1'b0;
        ev_fall = cyc + S + 1;
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                reset = 1'b1;
                tick(2);
                reset = 1'b0;
                track = 1'b0;
            end
            if (chg && i == 30) tx_data = {$urandom, $urandom};
            p = (i / W) * W + (W - 1 - i % W);
            mosi = (i < FL) ? mo[p] : 1'($urandom);
            tick(4);
            b = miso;
            if (i < FL) begin
                mi[p]     = b;
                exp_mi[p] = snap[p];
            end else if (track) begin
                chk("miso_tail", FL'(b), '0);
            end
            sck = 1'b1;
            if (coinc && i == nbits - 1) begin
                ssel = 1'b1;
                if (track) begin
                    ev_good = 1'b0;
                    ev_rise = cyc + S + 1;
                end
            end
            tick(4);
            sck = 1'b0;
        end
        if (!coinc) begin
            tick(4);
            ssel = 1'b1;
            if (track) begin
                ev_good = (nbits == FL);
                ev_rx   = mo;
                ev_rise = cyc + S + 1;
            end
        end
        tick(gap);
        if (track) chk("miso_frame", mi, exp_mi);
    endtask

    initial begin
        logic [FL-1:0] mi;
        logic [FL-1:0] snap;
        int            nb;

        tick(4);
        chk("rst_cnt",  FL'(frame_cnt), '0);
        chk("rst_rx",   rx_data, '0);
        chk("rst_miso", FL'(miso), '0);
        reset = 1'b0;
        tick(6);

        tx_data = 64'hDEADBEEF_12345678;
        frame(64'h40000000_3F800000, 64, -1, 0, 0, 6, mi, snap);
        chk("lit_miso", mi, 64'hDEADBEEF_12345678);
        chk("lit_rx",   rx_data, 64'h40000000_3F800000);
        chk("lit_cnt",  FL'(frame_cnt), FL'(1));
        chk("lit_busy", FL'(busy), '0);

        frame({$urandom, $urandom}, 40, -1, 0, 0, 6, mi, snap);
        chk("short_rx",  rx_data, 64'h40000000_3F800000);
        chk("short_cnt", FL'(frame_cnt), FL'(1));

        frame({$urandom, $urandom}, 65, -1, 0, 0, 6, mi, snap);
        chk("long_rx",  rx_data, 64'h40000000_3F800000);
        chk("long_cnt", FL'(frame_cnt), FL'(1));

        frame({$urandom, $urandom}, 64, -1, 1, 0, 6, mi, snap);
        chk("coinc_cnt", FL'(frame_cnt), FL'(1));

        frame({$urandom, $urandom}, 64, 20, 0, 0, 6, mi, snap);
        chk("rstmid_cnt", FL'(frame_cnt), '0);
        frame(64'h00000002_00000001, 64, -1, 0, 0, 6, mi, snap);
        chk("after_rst_rx",  rx_data, 64'h00000002_00000001);
        chk("after_rst_cnt", FL'(frame_cnt), FL'(1));

        for (int k = 0; k < 3; k++) begin
            tx_data = {$urandom, $urandom};
            frame({$urandom, $urandom}, 64, -1, 0, 1, S + 2, mi, snap);
        end
        chk("b2b_cnt", FL'(frame_cnt), FL'(4));

        for (int k = 0; k < 6; k++) begin
            nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 70)) : FL;
            tx_data = {$urandom, $urandom};
            frame({$urandom, $urandom}, nb, -1, 0,
                  1'($urandom), int'($urandom_range(4, 9)), mi, snap);
        end

        tick(1);
        force dut.frame_cnt_q = 16'hFFFF;
        ev_pre = cyc;
        tick(1);
        release dut.frame_cnt_q;
        tx_data = {$urandom, $urandom};
        frame({$urandom, $urandom}, 64, -1, 0, 0, 6, mi, snap);
        chk("wrap_cnt", FL'(frame_cnt), '0);

        tick(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
